// File: rtl/vx_lsu_block_arbiter.sv
// Round-robin arbiter sharing one dcache request/response channel between LSU block
// streams, with per-requester read credits. Optional perf counters: `LSU_ARB_PERF_EN.
module vx_lsu_block_arbiter #(
  parameter int NUM_INPUTS  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int SEL_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int OUT_TAG_WIDTH = TAG_WIDTH + SEL_BITS,
  localparam int CNT_W         = $clog2(MAX_PENDING + 1),
  localparam int BE_W          = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_req_valid,
  input  logic [NUM_INPUTS-1:0]            in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_INPUTS*BE_W-1:0]       in_req_byteen,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_INPUTS-1:0]            in_req_ready,
  output logic [NUM_INPUTS-1:0]            in_rsp_valid,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] in_rsp_data,
  output logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]            in_rsp_ready,
  output logic                             out_req_valid,
  output logic                             out_req_rw,
  output logic [ADDR_WIDTH-1:0]            out_req_addr,
  output logic [BE_W-1:0]                  out_req_byteen,
  output logic [DATA_WIDTH-1:0]            out_req_data,
  output logic [OUT_TAG_WIDTH-1:0]         out_req_tag,
  input  logic                             out_req_ready,
  input  logic                             out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            out_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]         out_rsp_tag,
  output logic                             out_rsp_ready
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [43:0]                      perf_conflict_cycles,
  output logic [43:0]                      perf_credit_stalls
`endif
);

  logic [CNT_W-1:0]         pend [NUM_INPUTS];
  logic [SEL_BITS-1:0]      rr_ptr;
  logic [SEL_BITS-1:0]      next_ptr;
  logic [SEL_BITS-1:0]      rsp_sel;
  logic [NUM_INPUTS-1:0]    eligible;
  logic [NUM_INPUTS-1:0]    credit_blocked;
  logic [NUM_INPUTS-1:0]    grant;
  logic                     found;
  logic                     stage_free;
  logic                     accept;
  logic                     nxt_rw;
  logic [ADDR_WIDTH-1:0]    nxt_addr;
  logic [BE_W-1:0]          nxt_byteen;
  logic [DATA_WIDTH-1:0]    nxt_data;
  logic [OUT_TAG_WIDTH-1:0] nxt_tag;

  assign stage_free = !out_req_valid || out_req_ready;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      credit_blocked[i] = !in_req_rw[i] && (pend[i] >= CNT_W'(MAX_PENDING));
      eligible[i]       = in_req_valid[i] && !credit_blocked[i];
    end
  end

  // Scan outward from rr_ptr; the first eligible input in rotated order wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    grant    = '0;
    found    = 1'b0;
    next_ptr = rr_ptr;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!found && eligible[i] && (((int'(rr_ptr) + k) % NUM_INPUTS) == i)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          next_ptr = SEL_BITS'((i + 1) % NUM_INPUTS);
        end
      end
    end
  end

  assign accept       = stage_free && found;
  assign in_req_ready = stage_free ? grant : '0;

  always_comb begin
    nxt_rw     = 1'b0;
    nxt_addr   = '0;
    nxt_byteen = '0;
    nxt_data   = '0;
    nxt_tag    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        nxt_rw     = in_req_rw[i];
        nxt_addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        nxt_byteen = in_req_byteen[i*BE_W +: BE_W];
        nxt_data   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        nxt_tag    = {in_req_tag[i*TAG_WIDTH +: TAG_WIDTH], SEL_BITS'(i)};
      end
    end
  end

  // NOTE: the staged payload is reset as well as the valid bit, so a cleared stage always reads back as zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_req_valid  <= 1'b0;
      out_req_rw     <= 1'b0;
      out_req_addr   <= '0;
      out_req_byteen <= '0;
      out_req_data   <= '0;
      out_req_tag    <= '0;
      rr_ptr         <= '0;
    end else if (accept) begin
      // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
      out_req_valid  <= 1'b1;
      out_req_rw     <= nxt_rw;
      out_req_addr   <= nxt_addr;
      out_req_byteen <= nxt_byteen;
      out_req_data   <= nxt_data;
      out_req_tag    <= nxt_tag;
      rr_ptr         <= next_ptr;
    end else if (out_req_ready) begin
      out_req_valid  <= 1'b0;
    end
  end

  // Responses steer by the select bits; an out-of-range select is accepted and dropped.
  assign rsp_sel     = out_rsp_tag[SEL_BITS-1:0];
  assign in_rsp_data = {NUM_INPUTS{out_rsp_data}};
  assign in_rsp_tag  = {NUM_INPUTS{out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS]}};

  always_comb begin
    in_rsp_valid  = '0;
    out_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_sel == SEL_BITS'(i)) begin
        in_rsp_valid[i] = out_rsp_valid;
        out_rsp_ready   = in_rsp_ready[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (in_req_ready[i] && !in_req_rw[i] && !(in_rsp_valid[i] && in_rsp_ready[i])) begin
          pend[i] <= pend[i] + CNT_W'(1);
        end else if (!(in_req_ready[i] && !in_req_rw[i]) && in_rsp_valid[i] && in_rsp_ready[i]
                     && (pend[i] != '0)) begin
          pend[i] <= pend[i] - CNT_W'(1);
        end
      end
    end
  end

`ifdef LSU_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict_cycles <= '0;
      perf_credit_stalls   <= '0;
    end else begin
      if (stage_free && ($countones(eligible) >= 2) && (perf_conflict_cycles != '1)) begin
        perf_conflict_cycles <= perf_conflict_cycles + 44'd1;
      end
      if (|(in_req_valid & credit_blocked) && (perf_credit_stalls != '1)) begin
        perf_credit_stalls <= perf_credit_stalls + 44'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_lsu_block_arbiter.sv
// Self-checking bench for vx_lsu_block_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of arbitration, credits and routing.
module tb_vx_lsu_block_arbiter;
  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int MP  = 4;
  localparam int BW  = DW / 8;
  localparam int OTW = TW + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*BW-1:0] in_req_byteen;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [N*DW-1:0] in_rsp_data;
  logic [N*TW-1:0] in_rsp_tag;
  logic            out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]   out_req_addr;
  logic [BW-1:0]   out_req_byteen;
  logic [DW-1:0]   out_req_data;
  logic [OTW-1:0]  out_req_tag;
  logic            out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]   out_rsp_data;
  logic [OTW-1:0]  out_rsp_tag;
`ifdef LSU_ARB_PERF_EN
  logic [43:0]     perf_conflict_cycles, perf_credit_stalls;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  vx_lsu_block_arbiter #(
    .NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_byteen(in_req_byteen), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_byteen(out_req_byteen), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready)
`ifdef LSU_ARB_PERF_EN
    , .perf_conflict_cycles(perf_conflict_cycles), .perf_credit_stalls(perf_credit_stalls)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_addr   = '0;
    in_req_byteen = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    out_req_ready = 1'b1;
    out_rsp_valid = 1'b0;
    out_rsp_data  = '0;
    out_rsp_tag   = '0;
    in_rsp_ready  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    in_req_valid = 2'b11;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", out_req_valid);
    end
    n_cmp++;
    if ({out_req_addr, out_req_tag, out_req_data} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got addr %h tag %h data %h expected zeros",
                         out_req_addr, out_req_tag, out_req_data);
    end
    n_cmp++;
    if (in_req_ready !== 2'b01) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 01", in_req_ready);
    end
    @(negedge clk);
    in_req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_alternate();
    int cnt[N];
    cnt[0] = 0; cnt[1] = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_req_valid  = 2'b11;
      in_req_rw     = 2'b00;
      in_req_tag    = {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
      out_req_ready = 1'b1;
      out_rsp_valid = out_req_valid;
      out_rsp_tag   = out_req_tag;
      in_rsp_ready  = 2'b11;
      #1;
      n_cmp++;
      if (in_req_ready !== 2'(1 << (k % 2))) begin
        n_fail++; $display("FAIL alt_grant[%0d]: got %b expected %b", k, in_req_ready, 2'(1 << (k % 2)));
      end
      for (int i = 0; i < N; i++) if (in_req_ready[i]) cnt[i]++;
      if (k > 0) begin
        n_cmp++;
        if (out_req_tag !== {8'hA0 + 8'(k - 1) + ((k - 1) % 2 == 1 ? 8'h10 : 8'h00), 1'((k - 1) % 2)}) begin
          n_fail++; $display("FAIL alt_tag[%0d]: got %h expected sel %0d", k, out_req_tag, (k - 1) % 2);
        end
      end
    end
    n_cmp++;
    if (cnt[0] != 4 || cnt[1] != 4) begin
      n_fail++; $display("FAIL alt_share: got %0d/%0d expected 4/4", cnt[0], cnt[1]);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_credit();
    apply_reset();
    for (int k = 0; k < MP + 1; k++) begin
      @(negedge clk);
      in_req_valid = 2'b01;
      in_req_rw    = 2'b00;
      in_req_addr  = {32'h0, 32'h40 + 32'(k)};
      #1;
      n_cmp++;
      if (in_req_ready !== (k < MP ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL credit_fill[%0d]: got %b expected %b", k, in_req_ready, (k < MP ? 2'b01 : 2'b00));
      end
    end
    @(negedge clk);
    in_req_valid = 2'b11;
    #1;
    n_cmp++;
    if (in_req_ready !== 2'b10) begin
      n_fail++; $display("FAIL credit_other: got %b expected 10", in_req_ready);
    end
    @(negedge clk);
    in_req_valid  = 2'b01;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h11, 1'b0};
    in_rsp_ready  = 2'b01;
    #1;
    n_cmp++;
    if ({in_req_ready, in_rsp_valid, out_rsp_ready} !== 5'b00_01_1) begin
      n_fail++; $display("FAIL credit_rsp: got ready %b rsp_valid %b rsp_ready %b expected 00 01 1",
                         in_req_ready, in_rsp_valid, out_rsp_ready);
    end
    @(negedge clk);
    out_rsp_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_req_ready !== 2'b01) begin
      n_fail++; $display("FAIL credit_release: got %b expected 01", in_req_ready);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_backpressure();
    logic [AW+DW+BW+OTW:0] exp_fields;
    apply_reset();
    @(negedge clk);
    in_req_valid  = 2'b01;
    in_req_rw     = 2'b01;
    in_req_addr   = {32'h0, 32'h100};
    in_req_data   = {32'h0, 32'hDEADBEEF};
    in_req_byteen = {4'h0, 4'hF};
    in_req_tag    = {8'h0, 8'h33};
    #1;
    n_cmp++;
    if (in_req_ready !== 2'b01) begin
      n_fail++; $display("FAIL bp_first: got %b expected 01", in_req_ready);
    end
    exp_fields = {1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 8'h33, 1'b0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_req_ready = 1'b0;
      in_req_valid  = 2'b11;
      in_req_rw     = 2'($urandom);
      in_req_addr   = {$urandom, $urandom};
      in_req_data   = {$urandom, $urandom};
      in_req_tag    = 16'($urandom);
      #1;
      n_cmp++;
      if (in_req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, in_req_ready);
      end
      n_cmp++;
      if ({out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} !== exp_fields
          || out_req_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b addr %h data %h tag %h expected addr 100 data deadbeef tag 066",
                           k, out_req_valid, out_req_addr, out_req_data, out_req_tag);
      end
    end
    @(negedge clk);
    in_req_valid  = 2'b00;
    out_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b1 || out_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL bp_complete: got v=%b addr %h expected 1 100", out_req_valid, out_req_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got %b expected 0", out_req_valid);
    end
    drive_idle();
  endtask

  task automatic test_rsp_route();
    apply_reset();
    @(negedge clk);
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h5A, 1'b1};
    out_rsp_data  = 32'h12345678;
    in_rsp_ready  = 2'b01;
    #1;
    n_cmp++;
    if (in_rsp_valid !== 2'b10 || in_rsp_tag[TW +: TW] !== 8'h5A || in_rsp_data[DW +: DW] !== 32'h12345678) begin
      n_fail++; $display("FAIL route_valid: got valid %b tag %h data %h expected 10 5a 12345678",
                         in_rsp_valid, in_rsp_tag[TW +: TW], in_rsp_data[DW +: DW]);
    end
    n_cmp++;
    if (out_rsp_ready !== 1'b0) begin
      n_fail++; $display("FAIL route_stall: got %b expected 0", out_rsp_ready);
    end
    in_rsp_ready = 2'b10;
    #1;
    n_cmp++;
    if (out_rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL route_ready: got %b expected 1", out_rsp_ready);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_req_valid = 2'b01;
      in_req_rw    = 2'b00;
      #1;
      n_cmp++;
      if (in_req_ready !== 2'b01) begin
        n_fail++; $display("FAIL mid_fill[%0d]: got %b expected 01", k, in_req_ready);
      end
    end
    @(negedge clk);
    in_req_valid  = 2'b00;
    out_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_staged: got %b expected 1", out_req_valid);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got %b expected 0", out_req_valid);
    end
    @(negedge clk);
    reset         = 1'b0;
    out_req_ready = 1'b1;
    out_rsp_valid = 1'b1;
    out_rsp_tag   = {8'h77, 1'b0};
    in_rsp_ready  = 2'b01;
    #1;
    n_cmp++;
    if (in_rsp_valid !== 2'b01 || in_rsp_tag[0 +: TW] !== 8'h77) begin
      n_fail++; $display("FAIL mid_stale: got valid %b tag %h expected 01 77", in_rsp_valid, in_rsp_tag[0 +: TW]);
    end
    for (int k = 0; k < MP + 1; k++) begin
      @(negedge clk);
      out_rsp_valid = 1'b0;
      in_req_valid  = 2'b01;
      #1;
      n_cmp++;
      if (in_req_ready !== (k < MP ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL mid_credit[%0d]: got %b expected %b", k, in_req_ready, (k < MP ? 2'b01 : 2'b00));
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random();
    int             m_pend[N];
    int             m_rr;
    logic           m_valid;
    logic [AW+DW+BW+OTW:0] m_fields;
    int             g, rsel;
    logic           sf;
    logic [N-1:0]   exp_ready, exp_rsp_valid;
    apply_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_rr = 0; m_valid = 1'b0; m_fields = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      in_req_valid  = 2'($urandom);
      in_req_rw     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      in_req_addr   = {$urandom, $urandom};
      in_req_data   = {$urandom, $urandom};
      in_req_byteen = 8'($urandom);
      in_req_tag    = 16'($urandom);
      out_req_ready = ($urandom_range(0, 3) != 0);
      out_rsp_valid = ($urandom_range(0, 2) != 0);
      rsel          = $urandom_range(0, N - 1);
      out_rsp_tag   = {8'($urandom), 1'(rsel)};
      out_rsp_data  = $urandom;
      in_rsp_ready  = 2'($urandom);
      #1;
      sf = !m_valid || out_req_ready;
      g = -1;
      if (sf) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (g < 0 && in_req_valid[idx] && (in_req_rw[idx] || m_pend[idx] < MP)) g = idx;
        end
      end
      exp_ready     = (g >= 0) ? 2'(1 << g) : 2'b00;
      exp_rsp_valid = out_rsp_valid ? 2'(1 << rsel) : 2'b00;
      n_cmp++;
      if (in_req_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, in_req_ready, exp_ready);
      end
      n_cmp++;
      if (out_req_valid !== m_valid || (m_valid &&
          {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} !== m_fields)) begin
        n_fail++; $display("FAIL rnd_out[%0d]: got v=%b %h expected v=%b %h", cyc, out_req_valid,
                           {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag}, m_valid, m_fields);
      end
      n_cmp++;
      if (in_rsp_valid !== exp_rsp_valid || out_rsp_ready !== in_rsp_ready[rsel]
          || in_rsp_tag !== {2{out_rsp_tag[OTW-1:1]}} || in_rsp_data !== {2{out_rsp_data}}) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got valid %b ready %b tag %h expected valid %b ready %b",
                           cyc, in_rsp_valid, out_rsp_ready, in_rsp_tag, exp_rsp_valid, in_rsp_ready[rsel]);
      end
      for (int i = 0; i < N; i++) begin
        logic inc, dec;
        inc = (g == i) && !in_req_rw[i];
        dec = out_rsp_valid && in_rsp_ready[rsel] && (rsel == i);
        if (inc && !dec) m_pend[i]++;
        else if (dec && !inc && m_pend[i] > 0) m_pend[i]--;
      end
      if (g >= 0) begin
        m_valid  = 1'b1;
        m_fields = {in_req_rw[g], in_req_addr[g*AW +: AW], in_req_data[g*DW +: DW],
                    in_req_byteen[g*BW +: BW], in_req_tag[g*TW +: TW], 1'(g)};
        m_rr     = (g + 1) % N;
      end else if (out_req_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

`ifdef LSU_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_req_valid  = 2'b11;
      in_req_rw     = 2'b00;
      out_req_ready = 1'b1;
      out_rsp_valid = out_req_valid;
      out_rsp_tag   = out_req_tag;
      in_rsp_ready  = 2'b11;
    end
    @(negedge clk);
    n_cmp++;
    if (perf_conflict_cycles !== 44'd10 || perf_credit_stalls !== 44'd0) begin
      n_fail++; $display("FAIL perf: got conflict %0d stalls %0d expected 10 0",
                         perf_conflict_cycles, perf_credit_stalls);
    end
    drive_idle();
  endtask
`endif

  initial begin
    drive_idle();
    test_reset();
    test_alternate();
    test_credit();
    test_backpressure();
    test_rsp_route();
    test_reset_mid();
    test_random();
`ifdef LSU_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
